// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises word reads/writes from two cores onto
// one shared byte-addressed data memory, rejecting misaligned or out-of-range accesses.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        c0_req_i,
    input  logic        c0_we_i,
    input  logic [31:0] c0_addr_i,
    input  logic [31:0] c0_wdata_i,
    output logic        c0_ack_o,
    output logic        c0_err_o,
    output logic [31:0] c0_rdata_o,
    input  logic        c1_req_i,
    input  logic        c1_we_i,
    input  logic [31:0] c1_addr_i,
    input  logic [31:0] c1_wdata_i,
    output logic        c1_ack_o,
    output logic        c1_err_o,
    output logic [31:0] c1_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_i,
    output logic        busy_o
);

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        r_id;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_grant;
    logic        w_grant_id;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;
    logic        w_access;
    logic        w_done;

    // Next-state and grant selection; on a tie the core not granted last wins.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_id  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (c0_req_i || c1_req_i) begin
                    w_grant     = 1'b1;
                    w_grant_id  = (c0_req_i && c1_req_i) ? ~r_last_grant : c1_req_i;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_sel_we    = w_grant_id ? c1_we_i    : c0_we_i;
    assign w_sel_addr  = w_grant_id ? c1_addr_i  : c0_addr_i;
    assign w_sel_wdata = w_grant_id ? c1_wdata_i : c0_wdata_i;
    assign w_sel_err   = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr > MAX_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction latch at grant, and per-core read data captured as ACCESS closes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rdata0     <= 32'd0;
            r_rdata1     <= 32'd0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_grant_id;
                r_id         <= w_grant_id;
                r_we         <= w_sel_we;
                r_err        <= w_sel_err;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
            end
            if (w_access && !r_we && !r_err) begin
                if (r_id) begin
                    r_rdata1 <= mem_data_i;
                end else begin
                    r_rdata0 <= mem_data_i;
                end
            end
        end
    end

    assign w_access = (r_state == S_ACCESS);
    assign w_done   = (r_state == S_DONE);

    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_wdata;
    assign mem_read_o  = w_access && !r_we && !r_err;
    // Gated by reset so an interrupted write never commits.
    assign mem_write_o = w_access && r_we && !r_err && !rst_i;

    assign c0_ack_o   = w_done && !r_id;
    assign c1_ack_o   = w_done && r_id;
    assign c0_err_o   = c0_ack_o && r_err;
    assign c1_err_o   = c1_ack_o && r_err;
    assign c0_rdata_o = r_rdata0;
    assign c1_rdata_o = r_rdata1;
    assign busy_o     = (r_state != S_IDLE);

endmodule
